onewire_presence_scan: RTL and testbench
========================================

// Module: onewire_presence_scan
// PURPOSE
//  Parametrised 1-Wire reset/presence detector for CHANNELS independent buses, sharing one timer.
//  Issues reset pulses on all buses in parallel, one-shot (i_start) or periodically (AUTO_POLL).
//  Reports per-channel presence, debounced over MISS_LIMIT misses, and flags stuck-low bus faults.
//  Sits between open-drain pads and status logic (LED/host); the successor to single-bus detect.
// PARAMETERS
//  CHANNELS    2        number of 1-Wire buses, 1..8
//  CLK_HZ      1000000  i_clk frequency; all *_US parameters are converted to cycles = US*CLK_HZ/1e6
//  RESET_US    480      master reset-low duration
//  WIN_LO_US   15       presence window start, measured from release
//  WIN_HI_US   240      presence window end (inclusive), measured from release
//  SLOT_US     960      total time from release to end of cycle (recovery), > WIN_HI_US
//  POLL_US     20000    period between cycle starts in AUTO_POLL mode, > RESET_US+SLOT_US
//  AUTO_POLL   1        1: free-running poll after reset; 0: cycles only on i_start
//  MISS_LIMIT  2        consecutive misses needed to clear o_present, 1..15
// PORTS
//  i_clk        in   1         system clock
//  i_rst        in   1         synchronous, active-high reset
//  i_start      in   1         single-cycle request for a detect cycle; ignored while o_busy=1
//  I_ONE_WIRE   in   CHANNELS  raw bus levels (asynchronous)
//  O_ONE_WIRE   out  CHANNELS  1 = pull bus low (open-drain enable)
//  o_busy       out  1         detect cycle in progress
//  o_done       out  1         one-cycle pulse when a cycle's results are committed
//  o_present    out  CHANNELS  debounced device present
//  o_fault      out  CHANNELS  bus low at cycle start or at end of slot (stuck low)
//  o_changed    out  1         one-cycle pulse, coincident with o_done, if o_present or o_fault changed
// BEHAVIOUR
//  Reset values: O_ONE_WIRE=0, o_busy=0, o_done=0, o_present=0, o_fault=0, o_changed=0.
//  Reset clears the miss counters and the poll timer; the FSM enters IDLE.
//  Reset mid-cycle releases all buses in the next cycle; no results are committed.
//  I_ONE_WIRE passes through a 2-flop synchroniser; in the text below, "line" means the synchronised value (2 cycles latency).
//  FSM states: IDLE -> PRECHK -> RST_LOW -> LISTEN -> EVAL -> IDLE.
//  IDLE:    enter PRECHK on i_start=1, or when AUTO_POLL=1 and the poll timer expires.
//           After reset with AUTO_POLL=1, the first cycle starts 1 cycle after i_rst deasserts.
//           The poll timer restarts on each cycle start; i_start in IDLE also restarts it.
//  PRECHK:  one cycle; latch pre_low[c] = ~line[c]. o_busy goes 1 here and stays 1 through EVAL.
//  RST_LOW: O_ONE_WIRE = all ones for exactly RESET_US cycles, then O_ONE_WIRE = 0.
//  LISTEN:  runs SLOT_US cycles, with k = 0 at the first released cycle.
//           seen[c] is set if line[c]=0 for any k in [WIN_LO,WIN_HI].
//           On the last LISTEN cycle, latch end_low[c] = ~line[c].
//  EVAL:    one cycle; all updates below are registered, o_done=1, o_busy drops to 0 on the next cycle.
//           fault[c] = pre_low[c] | end_low[c]
//           hit[c] = seen[c] & ~fault[c]
//           hit:  present=1, miss counter cleared
//           miss: counter saturating-increments; present cleared when counter reaches MISS_LIMIT
//           fault: present=0 immediately, counter set to MISS_LIMIT
//  All channels are evaluated independently and in the same EVAL cycle.
//  i_start coincident with an AUTO_POLL expiry produces one cycle only.
//  Counter widths: clog2 of the largest cycle count; parameter checks (e.g. SLOT_US <= WIN_HI_US) stop elaboration.
// TESTING
//  (CLK_HZ=1e6, CHANNELS=2, AUTO_POLL=0, MISS_LIMIT=2; all timings in cycles)
//  1. i_start; ch0 driven low from k=30 to k=150 -> O_ONE_WIRE=2'b11 for exactly 480 cycles; o_present=2'b01, o_changed=1 at o_done.
//  2. Both lines idle-high, one i_start -> o_present unchanged, o_changed=0. A second miss clears o_present[0] and pulses o_changed.
//  3. ch1 held low from before i_start -> o_fault[1]=1, o_present[1]=0; release and rerun with a valid pulse -> o_fault[1]=0, o_present[1]=1.
//  4. Window edges: low only at k=14 -> miss; low only at k=15 or k=240 -> hit; low only at k=241 -> miss.
//  5. AUTO_POLL=1, POLL_US=20000 -> cycle starts 20000 cycles apart; i_start while busy is ignored.
//     i_start on the same cycle as a poll expiry starts exactly one cycle.
//  6. Assert i_rst at k=100 of LISTEN -> next cycle: O_ONE_WIRE=0, o_busy=0, o_present=0, no o_done.

Source files
------------

// File: rtl/onewire_presence_scan.sv
// rtl/onewire_presence_scan.sv - multi-channel 1-Wire reset/presence scanner
// One slot timer drives every bus in lockstep; presence is debounced per channel.
module onewire_presence_scan #(
  parameter int CHANNELS   = 2,
  parameter int CLK_HZ     = 1000000,
  parameter int RESET_US   = 480,
  parameter int WIN_LO_US  = 15,
  parameter int WIN_HI_US  = 240,
  parameter int SLOT_US    = 960,
  parameter int POLL_US    = 20000,
  parameter int AUTO_POLL  = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [CHANNELS-1:0] I_ONE_WIRE,
  output logic [CHANNELS-1:0] O_ONE_WIRE,
  output logic                o_busy,
  output logic                o_done,
  output logic [CHANNELS-1:0] o_present,
  output logic [CHANNELS-1:0] o_fault,
  output logic                o_changed
);
  function automatic int us2cyc(input int us);
    return int'((longint'(us) * longint'(CLK_HZ)) / longint'(1000000));
  endfunction

  localparam int RESET_CYC  = us2cyc(RESET_US);
  localparam int WIN_LO_CYC = us2cyc(WIN_LO_US);
  localparam int WIN_HI_CYC = us2cyc(WIN_HI_US);
  localparam int SLOT_CYC   = us2cyc(SLOT_US);
  localparam int POLL_CYC   = us2cyc(POLL_US);
  localparam int CNT_MAX    = (RESET_CYC > SLOT_CYC) ? RESET_CYC : SLOT_CYC;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int PW         = $clog2(POLL_CYC + 1);
  localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

  if (CHANNELS < 1 || CHANNELS > 8 || MISS_LIMIT < 1 || MISS_LIMIT > 15 || RESET_CYC < 1 ||
      WIN_LO_CYC > WIN_HI_CYC || SLOT_CYC <= WIN_HI_CYC ||
      POLL_CYC <= RESET_CYC + SLOT_CYC) begin : g_param_check
    $fatal(1, "onewire_presence_scan: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_PRECHK, S_RST_LOW, S_LISTEN, S_EVAL} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CHANNELS-1:0] r_sync1, r_sync2;
  logic [CHANNELS-1:0] r_pre_low, r_end_low, r_seen, r_present, r_fault;
  logic [CHANNELS-1:0] w_flt, w_present_nx;
  logic [3:0]          r_miss    [CHANNELS];
  logic [3:0]          w_miss_nx [CHANNELS];
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_poll;
  logic                r_done, r_changed;
  logic                w_go, w_rst_end, w_lst_end, w_in_win;

  assign w_go      = (r_state == S_IDLE) && (i_start || ((AUTO_POLL != 0) && (r_poll == '0)));
  assign w_rst_end = (r_cnt == CW'(RESET_CYC - 1));
  assign w_lst_end = (r_cnt == CW'(SLOT_CYC - 1));
  assign w_in_win  = (r_cnt >= CW'(WIN_LO_CYC)) && (r_cnt <= CW'(WIN_HI_CYC));
  assign w_flt     = r_pre_low | r_end_low;

  // Pads are asynchronous; the synchroniser is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    r_sync1 <= I_ONE_WIRE;
    r_sync2 <= r_sync1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    O_ONE_WIRE = '0;
    o_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_go) w_next = S_PRECHK;
      end
      S_PRECHK: w_next = S_RST_LOW;
      S_RST_LOW: begin
        O_ONE_WIRE = '1;
        if (w_rst_end) w_next = S_LISTEN;
      end
      S_LISTEN: if (w_lst_end) w_next = S_EVAL;
      S_EVAL:   w_next = S_IDLE;
      default: begin
        w_next = S_IDLE;
        o_busy = 1'b0;
      end
    endcase
  end

  // Poll timer reloads on every accepted start, so i_start and expiry merge into one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_poll <= '0;
    end else begin
      if ((r_state == S_RST_LOW && !w_rst_end) || r_state == S_LISTEN) r_cnt <= r_cnt + CW'(1);
      else                                                             r_cnt <= '0;
      if (w_go)                r_poll <= PW'(POLL_CYC - 1);
      else if (r_poll != '0)   r_poll <= r_poll - PW'(1);
    end
  end

  always_comb begin
    w_present_nx = r_present;
    for (int c = 0; c < CHANNELS; c++) begin
      w_miss_nx[c] = r_miss[c];
      if (w_flt[c]) begin
        w_present_nx[c] = 1'b0;
        w_miss_nx[c]    = MISS_LIM;
      end else if (r_seen[c]) begin
        w_present_nx[c] = 1'b1;
        w_miss_nx[c]    = '0;
      end else begin
        if (r_miss[c] != MISS_LIM) w_miss_nx[c] = r_miss[c] + 4'd1;
        if (w_miss_nx[c] == MISS_LIM) w_present_nx[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pre_low <= '0;
      r_end_low <= '0;
      r_seen    <= '0;
      r_present <= '0;
      r_fault   <= '0;
      r_done    <= 1'b0;
      r_changed <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) r_miss[c] <= '0;
    end else begin
      r_done    <= (r_state == S_EVAL);
      r_changed <= (r_state == S_EVAL) && ((w_present_nx != r_present) || (w_flt != r_fault));
      case (r_state)
        S_PRECHK: begin
          r_pre_low <= ~r_sync2;
          r_seen    <= '0;
        end
        S_LISTEN: begin
          if (w_in_win)  r_seen    <= r_seen | ~r_sync2;
          if (w_lst_end) r_end_low <= ~r_sync2;
        end
        S_EVAL: begin
          r_present <= w_present_nx;
          r_fault   <= w_flt;
          for (int c = 0; c < CHANNELS; c++) r_miss[c] <= w_miss_nx[c];
        end
        default: ;
      endcase
    end
  end

  assign o_done    = r_done;
  assign o_changed = r_changed;
  assign o_present = r_present;
  assign o_fault   = r_fault;
endmodule

// File: tb/tb_onewire_presence_scan.sv
// tb/tb_onewire_presence_scan.sv - bench for onewire_presence_scan
module tb_onewire_presence_scan;
  localparam int RESET = 480, SLOT = 960, WIN_LO = 15, WIN_HI = 240, LIM = 2, POLL = 20000;
  // Cycle indices within one run: i_start at J_START, PRECHK follows, k=0 at J_LST.
  localparam int J_START = 2, J_PRE = 3, J_LST = J_PRE + 1 + RESET, J_EVAL = J_LST + SLOT;
  localparam int NCYC = J_EVAL + 2;
  localparam int CYC_LEN = 1 + RESET + SLOT + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_rst, i_start;
  logic [1:0] I_ONE_WIRE, O_ONE_WIRE, o_present, o_fault;
  logic       o_busy, o_done, o_changed;
  logic       a_rst, a_start;
  logic [1:0] a_ow_in, a_ow_out, a_pres, a_flt;
  logic       a_busy, a_done, a_chg;

  onewire_presence_scan #(.CHANNELS(2), .AUTO_POLL(0), .MISS_LIMIT(LIM)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .I_ONE_WIRE(I_ONE_WIRE),
    .O_ONE_WIRE(O_ONE_WIRE), .o_busy(o_busy), .o_done(o_done), .o_present(o_present),
    .o_fault(o_fault), .o_changed(o_changed));

  onewire_presence_scan #(.CHANNELS(2), .AUTO_POLL(1), .POLL_US(POLL)) u_auto (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .I_ONE_WIRE(a_ow_in),
    .O_ONE_WIRE(a_ow_out), .o_busy(a_busy), .o_done(a_done), .o_present(a_pres),
    .o_fault(a_flt), .o_changed(a_chg));

  int   total = 0, bad = 0;
  logic auto_done = 1'b0;

  logic [1:0] m_pres, m_flt;
  int         m_miss [2];
  logic       m_chg;
  logic [1:0] wave [NCYC];

  typedef struct {
    int a0, b0, a1, b1;
    logic [1:0] pre, endl, e_pres, e_flt;
    logic e_chg;
  } vec_t;
  vec_t vecs [11];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Pad waveform for one run; a/b are LISTEN k spans where the raw pad is held low.
  task automatic build_wave(input int a0, input int b0, input int a1, input int b1,
                            input logic [1:0] pre, input logic [1:0] endl);
    int a [2];
    int b [2];
    a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
    for (int j = 0; j < NCYC; j++) begin
      wave[j] = 2'b11;
      for (int c = 0; c < 2; c++) begin
        if (pre[c] && j <= J_PRE + 100) wave[j][c] = 1'b0;
        if (a[c] >= 0 && j >= J_LST + a[c] && j <= J_LST + b[c]) wave[j][c] = 1'b0;
        if (endl[c] && j >= J_LST + 900) wave[j][c] = 1'b0;
      end
    end
  endtask

  // Reference: line is the pad value two cycles earlier; apply the evaluation rules.
  task automatic model_eval();
    logic [1:0] old_p, old_f;
    logic       pre_l, end_l, seen;
    old_p = m_pres;
    old_f = m_flt;
    for (int c = 0; c < 2; c++) begin
      pre_l = !wave[J_PRE - 2][c];
      end_l = !wave[J_LST + SLOT - 1 - 2][c];
      seen  = 1'b0;
      for (int k = WIN_LO; k <= WIN_HI; k++) if (!wave[J_LST + k - 2][c]) seen = 1'b1;
      m_flt[c] = pre_l | end_l;
      if (m_flt[c]) begin
        m_pres[c] = 1'b0;
        m_miss[c] = LIM;
      end else if (seen) begin
        m_pres[c] = 1'b1;
        m_miss[c] = 0;
      end else begin
        if (m_miss[c] < LIM) m_miss[c]++;
        if (m_miss[c] >= LIM) m_pres[c] = 1'b0;
      end
    end
    m_chg = (m_pres != old_p) || (m_flt != old_f);
  endtask

  task automatic run_cycle(input int rst_at, input string tag);
    int e_ow, e_busy, e_done;
    e_ow = 0; e_busy = 0; e_done = 0;
    for (int j = 0; j < NCYC; j++) begin
      @(posedge clk); #1;
      if (rst_at >= 0 && j == rst_at + 1) begin
        chk({tag, "_ow"}, int'(O_ONE_WIRE), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_present"}, int'(o_present), 0);
        chk({tag, "_fault"}, int'(o_fault), 0);
        i_rst = 1'b0;
        return;
      end
      if (O_ONE_WIRE != ((j > J_PRE && j < J_LST) ? 2'b11 : 2'b00)) e_ow++;
      if (o_busy != (j >= J_PRE && j <= J_EVAL)) e_busy++;
      if (o_done != (j == J_EVAL + 1)) e_done++;
      I_ONE_WIRE = wave[j];
      i_start    = (j == J_START);
      i_rst      = (j == rst_at);
    end
    chk({tag, "_ow_shape"}, e_ow, 0);
    chk({tag, "_busy_shape"}, e_busy, 0);
    chk({tag, "_done_shape"}, e_done, 0);
  endtask

  initial begin : main_blk
    int ra [2];
    int rb [2];
    logic [1:0] rpre, rend;
    int n_done, n_busy;
    vecs[0]  = '{30, 150, -1, -1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
    vecs[1]  = '{-1, -1, -1, -1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0};
    vecs[2]  = '{-1, -1, -1, -1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
    vecs[3]  = '{30, 150, -1, -1, 2'b10, 2'b00, 2'b01, 2'b10, 1'b1};
    vecs[4]  = '{30, 150, 30, 150, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1};
    vecs[5]  = '{12, 12, 13, 13, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0};
    vecs[6]  = '{238, 238, 239, 239, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0};
    vecs[7]  = '{239, 239, 12, 12, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
    vecs[8]  = '{13, 13, 238, 238, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1};
    vecs[9]  = '{30, 150, 30, 150, 2'b00, 2'b01, 2'b10, 2'b01, 1'b1};
    vecs[10] = '{30, 150, 30, 150, 2'b00, 2'b00, 2'b11, 2'b00, 1'b1};

    i_rst = 1'b1; i_start = 1'b0; I_ONE_WIRE = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ow", int'(O_ONE_WIRE), 0);
    chk("reset_busy", int'(o_busy), 0);
    chk("reset_done", int'(o_done), 0);
    chk("reset_present", int'(o_present), 0);
    chk("reset_fault", int'(o_fault), 0);
    chk("reset_changed", int'(o_changed), 0);
    i_rst = 1'b0;
    m_pres = 2'b00; m_flt = 2'b00; m_miss[0] = 0; m_miss[1] = 0;

    for (int v = 0; v < 11; v++) begin
      build_wave(vecs[v].a0, vecs[v].b0, vecs[v].a1, vecs[v].b1, vecs[v].pre, vecs[v].endl);
      model_eval();
      run_cycle(-1, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_present", v), int'(o_present), int'(vecs[v].e_pres));
      chk($sformatf("vec%0d_fault", v), int'(o_fault), int'(vecs[v].e_flt));
      chk($sformatf("vec%0d_changed", v), int'(o_changed), int'(vecs[v].e_chg));
    end

    // Reset at k=100 of LISTEN: buses released, nothing committed afterwards.
    build_wave(30, 150, 30, 150, 2'b00, 2'b00);
    run_cycle(J_LST + 100, "midrst");
    m_pres = 2'b00; m_flt = 2'b00; m_miss[0] = 0; m_miss[1] = 0;
    I_ONE_WIRE = 2'b11;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      if (o_done) n_done++;
      if (o_busy || O_ONE_WIRE != 2'b00) n_busy++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_idle", n_busy, 0);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          ra[c] = -1; rb[c] = -1;
        end else begin
          ra[c] = int'($urandom_range(0, 300));
          rb[c] = ra[c] + int'($urandom_range(0, 20));
        end
        rpre[c] = ($urandom_range(0, 7) == 0);
        rend[c] = ($urandom_range(0, 7) == 0);
      end
      build_wave(ra[0], rb[0], ra[1], rb[1], rpre, rend);
      model_eval();
      run_cycle(-1, $sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_present", r), int'(o_present), int'(m_pres));
      chk($sformatf("rnd%0d_fault", r), int'(o_fault), int'(m_flt));
      chk($sformatf("rnd%0d_changed", r), int'(o_changed), int'(m_chg));
    end

    for (int i = 0; i < 30000 && !auto_done; i++) @(posedge clk);
    chk("auto_finished", int'(auto_done), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : auto_blk
    int   rises [$];
    int   falls [$];
    logic prev;
    a_rst = 1'b1; a_start = 1'b0; a_ow_in = 2'b11;
    repeat (3) @(posedge clk);
    prev = 1'b0;
    for (int cy = 0; cy < 43000; cy++) begin
      @(posedge clk); #1;
      if (a_busy && !prev) rises.push_back(cy);
      if (!a_busy && prev) falls.push_back(cy);
      prev  = a_busy;
      a_rst = 1'b0;
      // One start mid-cycle (must be ignored), one on the same cycle as the poll expiry.
      a_start = (rises.size() == 1 && cy == rises[0] + 100) ||
                (rises.size() == 2 && cy == rises[1] + POLL - 1);
      if (rises.size() == 3 && cy == rises[2] + CYC_LEN + 200) break;
    end
    chk("auto_rise_count", rises.size(), 3);
    chk("auto_fall_count", falls.size(), 3);
    if (rises.size() >= 3) begin
      chk("auto_first_start", rises[0], 1);
      chk("auto_period1", rises[1] - rises[0], POLL);
      chk("auto_period2", rises[2] - rises[1], POLL);
    end
    if (rises.size() >= 3 && falls.size() >= 3) begin
      chk("auto_len1", falls[0] - rises[0], CYC_LEN);
      chk("auto_len3", falls[2] - rises[2], CYC_LEN);
    end
    auto_done = 1'b1;
  end
endmodule
